// File: rtl/dmem_responder.sv
// Data-memory responder for the Memory stage: word loads and byte-masked stores after WAIT_STATES wait cycles.
// Optional build macro DMEM_BOUNDS_CHECK_EN adds out-of-range detection (MemErr, store suppression, DEADBEEF loads).
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReqM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [3:0]  byteEnable,
    output logic [31:0] ReadDataM,
    output logic        MemStall,
    output logic        MemDone,
    output logic        MemErr
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t         r_state, w_next;
    logic [3:0]     r_cnt;
    logic [AW-1:0]  r_idx;
    logic [31:0]    r_wdata;
    logic [3:0]     r_be;
    logic           r_we;
    logic           r_oob;
    logic           r_err;
    logic [31:0]    r_rdata;
    logic [31:0]    r_mem [DEPTH_WORDS];

    logic           w_in_idle, w_acc, w_oob_in;
    logic [AW-1:0]  w_idx_in, w_a_idx;
    logic [31:0]    w_a_wdata;
    logic [3:0]     w_a_be;
    logic           w_a_we, w_a_oob;

    assign w_idx_in  = ALUResultM[AW+1:2];
    assign w_in_idle = (r_state == S_IDLE);

`ifdef DMEM_BOUNDS_CHECK_EN
    assign w_oob_in = |ALUResultM[31:AW+2];
    assign MemErr   = (r_state == S_DONE) && r_err;
    logic w_unused;
    assign w_unused = ^ALUResultM[1:0];
`else
    // Upper address bits are dropped, so accesses wrap modulo DEPTH_WORDS*4.
    assign w_oob_in = 1'b0;
    assign MemErr   = 1'b0;
    logic w_unused;
    assign w_unused = ^{ALUResultM, r_err};
`endif

    // Zero-wait accesses act on live inputs in IDLE; otherwise on the captured request.
    assign w_acc     = reset && ((w_in_idle && MemReqM && WAIT_STATES == 0) ||
                                 (r_state == S_WAIT && r_cnt == 4'd1));
    assign w_a_idx   = w_in_idle ? w_idx_in   : r_idx;
    assign w_a_wdata = w_in_idle ? WriteDataM : r_wdata;
    assign w_a_be    = w_in_idle ? byteEnable : r_be;
    assign w_a_we    = w_in_idle ? MemWriteM  : r_we;
    assign w_a_oob   = w_in_idle ? w_oob_in   : r_oob;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (MemReqM) w_next = (WAIT_STATES == 0) ? S_DONE : S_WAIT;
            S_WAIT:  if (r_cnt == 4'd1) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_wdata <= 32'h0;
            r_be    <= 4'h0;
            r_we    <= 1'b0;
            r_oob   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= 32'h0;
        end else begin
            r_state <= w_next;
            if (w_in_idle && MemReqM) begin
                r_idx   <= w_idx_in;
                r_wdata <= WriteDataM;
                r_be    <= byteEnable;
                r_we    <= MemWriteM;
                r_oob   <= w_oob_in;
                r_cnt   <= 4'(WAIT_STATES);
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_acc) begin
                r_err <= w_a_oob;
                if (!w_a_we) r_rdata <= w_a_oob ? 32'hDEAD_BEEF : r_mem[w_a_idx];
            end
        end
    end

    // Array is never cleared; the write is gated by reset through w_acc.
    always_ff @(posedge clk) begin
        if (w_acc && w_a_we && !w_a_oob) begin
            for (int i = 0; i < 4; i++) begin
                if (w_a_be[i]) r_mem[w_a_idx][8*i +: 8] <= w_a_wdata[8*i +: 8];
            end
        end
    end

    assign ReadDataM = r_rdata;
    assign MemStall  = (w_in_idle && MemReqM) || (r_state == S_WAIT);
    assign MemDone   = (r_state == S_DONE);
endmodule
